// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync FIFO family.
// Read-mode encodings and a width helper.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: one write port, one async read address, no reset.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, count, status, sticky errors, read path.
// Ports: clk/rst_n/clr, wr_*/full/almost_full, rd_*/empty/almost_empty, count, overflow/underflow.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam bit IS_FWFT = (FWFT == FIFO_MODE_FWFT);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH))
  begin : g_bad_thresh
    $error("sync_fifo_ctrl: need 0 < AE_THRESH < AF_THRESH <= DEPTH");
  end

  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)
  begin : g_bad_mode
    $error("sync_fifo_ctrl: FWFT must be 0 or 1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status comes from the registered count only.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A full FIFO rejects a write even when a read pops the same cycle.
  assign wr_ok = wr_en && !full && !clr;
  assign rd_ok = rd_en && !empty && !clr;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      if (wr_en && full) ovf_d = 1'b1;
      if (rd_en && empty) udf_d = 1'b1;
      rd_valid_d = rd_ok;
      if (rd_ok) rd_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // FWFT shows the head word directly; standard mode uses the read register.
  assign rd_valid = IS_FWFT ? !empty : rd_valid_q;
  assign rd_data  = IS_FWFT ? (empty ? '0 : mem_rdata) : rd_data_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl in both read modes.
// Queue-based reference model; monitor compares on the falling edge.
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic          s_full, s_af, s_empty, s_ae, s_ovf, s_udf, s_rv;
  logic [DW-1:0] s_rd;
  logic [AW:0]   s_cnt;
  logic          f_full, f_af, f_empty, f_ae, f_ovf, f_udf, f_rv;
  logic [DW-1:0] f_rd;
  logic [AW:0]   f_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_af),
    .rd_en(rd_en), .rd_data(s_rd), .rd_valid(s_rv),
    .empty(s_empty), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data),
    .full(f_full), .almost_full(f_af),
    .rd_en(rd_en), .rd_data(f_rd), .rd_valid(f_rv),
    .empty(f_empty), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO is a queue; accepted reads feed the scoreboard.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      int sz;
      sz = mq.size();
      if (rd_en) begin
        if (sz == 0) m_udf = 1'b1;
        else exp_q.push_back(mq.pop_front());
      end
      if (wr_en) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else mq.push_back(wr_data);
      end
    end
  end

  task automatic check_status();
    int sz;
    sz = mq.size();
    chk("s_count", 32'(s_cnt), 32'(sz));
    chk("s_full", 32'(s_full), 32'(sz == DEPTH));
    chk("s_empty", 32'(s_empty), 32'(sz == 0));
    chk("s_afull", 32'(s_af), 32'(sz >= AF));
    chk("s_aempty", 32'(s_ae), 32'(sz <= AE));
    chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
    chk("s_udf", 32'(s_udf), 32'(m_udf));
    chk("f_count", 32'(f_cnt), 32'(sz));
    chk("f_full", 32'(f_full), 32'(sz == DEPTH));
    chk("f_empty", 32'(f_empty), 32'(sz == 0));
    chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("f_udf", 32'(f_udf), 32'(m_udf));
  endtask

  // Monitor: pops the scoreboard whenever standard mode presents a word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("s_rd_valid", 32'(s_rv), 32'(exp_q.size() != 0));
        if (s_rv && exp_q.size() != 0) chk("s_rd_data", 32'(s_rd), 32'(exp_q.pop_front()));
        else exp_q.delete();
        chk("f_rd_valid", 32'(f_rv), 32'(mq.size() != 0));
        chk("f_rd_data", 32'(f_rd), mq.size() != 0 ? 32'(mq[0]) : 32'd0);
        check_status();
      end
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit c);
    @(negedge clk);
    #1;
    wr_en = w;
    wr_data = d;
    rd_en = r;
    clr = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int wp, rp;
    rst_n = 1'b0;
    #23;
    chk("rst_s_count", 32'(s_cnt), 32'd0);
    chk("rst_s_empty", 32'(s_empty), 32'd1);
    chk("rst_s_aempty", 32'(s_ae), 32'd1);
    chk("rst_s_full", 32'(s_full), 32'd0);
    chk("rst_s_afull", 32'(s_af), 32'd0);
    chk("rst_s_rv", 32'(s_rv), 32'd0);
    chk("rst_s_rd", 32'(s_rd), 32'd0);
    chk("rst_f_rv", 32'(f_rv), 32'd0);
    rst_n = 1'b1;

    for (int i = 1; i <= 10; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);

    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'($urandom_range(0, 254)), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);

    for (int i = 0; i < 5; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    cyc(1'b1, 8'h33, 1'b1, 1'b1);
    idle(2);

    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);

    for (int i = 0; i < 7; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    idle(1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_s_count", 32'(s_cnt), 32'd0);
    chk("async_s_empty", 32'(s_empty), 32'd1);
    chk("async_s_full", 32'(s_full), 32'd0);
    chk("async_f_count", 32'(f_cnt), 32'd0);
    chk("async_f_rv", 32'(f_rv), 32'd0);
    #3;
    rst_n = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);

    for (int b = 0; b < 12; b++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++)
        cyc($urandom_range(0, 99) < wp, DW'($urandom),
            $urandom_range(0, 99) < rp, $urandom_range(0, 199) == 0);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
